l2_norm_arbiter: RTL and testbench
==================================

// Module: l2_norm_arbiter
// PURPOSE
//  Shares one L2-norm accumulate datapath between NUM_REQ vector requesters.
//  Grants round-robin and clears the datapath before each vector.
//  Streams VEC_LEN 8-bit samples from the granted requester, waits for the final datapath result and returns it with the requester id.
//  Sits between the requester clients and the single norm datapath instance.
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..8)
//  VEC_LEN   8   samples per vector (1..255)
//  TIMEOUT   64  max cycles in DRAIN before forced error result
// PORTS
//  clk           in   1          clock, all logic posedge
//  reset         in   1          synchronous, active-high
//  req           in   NUM_REQ    requester i wants a vector slot; held until result or abort
//  req_a         in   8*NUM_REQ  sample bus, requester i at [8i+7:8i]
//  req_valid     in   NUM_REQ    sample valid per requester
//  gnt           out  NUM_REQ    one-hot; high only in STREAM; sample taken when gnt[i]&req_valid[i]
//  dp_reset      out  1          datapath clear (registered)
//  dp_a          out  8          sample to datapath (registered)
//  dp_valid_in   out  1          sample valid to datapath (registered)
//  dp_g          in   10         datapath result
//  dp_valid_out  in   1          one pulse per accepted datapath sample
//  dp_overflow   in   1          datapath overflow flag
//  res_valid     out  1          one-cycle result strobe
//  res_id        out  $clog2(NUM_REQ)  requester owning result
//  res_g         out  10         captured dp_g
//  res_overflow  out  1          OR of dp_overflow over the vector
//  res_error     out  1          1 = abort or timeout; res_g then 0
// BEHAVIOUR
//  Reset:
//   - state IDLE, rr pointer 0, gnt 0, dp_valid_in 0, dp_a 0, res_* 0.
//   - dp_reset=1 while reset is high.
//  FSM IDLE -> CLEAR -> STREAM -> DRAIN -> RESULT -> IDLE. ABORT and timeout also route to RESULT.
//  IDLE:
//   - If any req, pick the first set bit at or above rr pointer (wrapping) and register owner.
//   - Next state CLEAR; rr pointer becomes owner+1 mod NUM_REQ.
//  CLEAR: exactly 1 cycle; dp_reset=1; gnt=0; sample count, pulse count and sticky overflow cleared.
//  STREAM:
//   - gnt[owner]=1. Each gnt&req_valid cycle, the next cycle drives dp_a=sample and dp_valid_in=1, and the sample count increments.
//   - After the VEC_LEN-th sample, gnt drops the following cycle; go to DRAIN.
//   - If req[owner] falls in STREAM: go to ABORT.
//  ABORT: 1 cycle with dp_reset=1, then RESULT with res_error=1, res_g=0.
//  DRAIN:
//   - Count dp_valid_out pulses, including any already seen in STREAM.
//   - On the VEC_LEN-th pulse, capture dp_g and go to RESULT.
//   - The cycle counter saturates at TIMEOUT. Reaching it forces RESULT with res_error=1 and dp_reset pulsed.
//  RESULT: res_valid=1 for 1 cycle with res_id=owner; next IDLE. Earliest next grant is 1 cycle later.
//  res_overflow = OR of dp_overflow sampled on each dp_valid_out of the vector.
//  Boundaries:
//   - gnt is never asserted outside STREAM. Samples from non-owners are ignored.
//   - dp_valid_out outside STREAM/DRAIN is ignored.
//   - The pulse counter never exceeds VEC_LEN.
//   - A new req arriving during a vector waits; fairness is strictly rotational.
//   - reset mid-vector: immediate IDLE, no result strobe, dp_reset high.
// TESTING
//  Bench datapath model: g = running sum of a, valid_out 2 cycles after valid_in.
//  1. req[0] only, samples 1..8 back-to-back -> one CLEAR pulse, res_valid, res_id=0, res_g=36, res_error=0.
//  2. req=4'b1111 held, each streams eight 10s -> results in id order 0,1,2,3, each res_g=80; then 0 again.
//  3. req[2] with req_valid gaps (1 on / 2 off), samples 5 x8 -> res_g=40; dp_valid_in only on taken samples.
//  4. req[1] drops after 3 samples -> dp_reset pulse, res_valid with res_error=1, res_g=0, res_id=1.
//  5. Model suppresses valid_out -> res_error=1 exactly TIMEOUT cycles after DRAIN entry.
//  6. Model raises dp_overflow on sample 4 -> res_overflow=1. Reset asserted mid-STREAM -> gnt=0 and no res_valid.

Source files
------------

// File: rtl/l2_norm_arbiter.sv
// l2_norm_arbiter: round-robin arbiter that shares one L2-norm accumulate datapath between requesters
module l2_norm_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int VEC_LEN = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [8*NUM_REQ-1:0]       req_a,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         gnt,
   output logic                       dp_reset,
   output logic [7:0]                 dp_a,
   output logic                       dp_valid_in,
   input  logic [9:0]                 dp_g,
   input  logic                       dp_valid_out,
   input  logic                       dp_overflow,
   output logic                       res_valid,
   output logic [$clog2(NUM_REQ)-1:0] res_id,
   output logic [9:0]                 res_g,
   output logic                       res_overflow,
   output logic                       res_error
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(VEC_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, ABORT, DRAIN, RESULT} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] rr_q, rr_d, owner_q, owner_d, pick, res_id_q, res_id_d;
   logic [CW-1:0] smp_q, smp_d, pls_q, pls_d;
   logic [TW-1:0] cyc_q, cyc_d;
   logic [7:0] dp_a_q, dp_a_d;
   logic [9:0] res_g_q, res_g_d;
   logic ovf_q, ovf_d, dp_reset_q, dp_reset_d, dp_valid_in_q, dp_valid_in_d;
   logic res_valid_q, res_valid_d, res_overflow_q, res_overflow_d, res_error_q, res_error_d;
   logic found, take, pulse, tmo;
   function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      return IW'(s >= NUM_REQ ? s - NUM_REQ : s);
   endfunction
   // scanning downward leaves the nearest requester at or above rr in pick
   always_comb begin
      pick  = rr_q;
      found = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (req[wrap(rr_q, i)]) begin
            pick  = wrap(rr_q, i);
            found = 1'b1;
         end
   end
   assign take  = state_q == STREAM && req_valid[owner_q];
   assign pulse = (state_q == STREAM || state_q == DRAIN) && dp_valid_out && pls_q != CW'(VEC_LEN);
   assign gnt   = state_q == STREAM ? NUM_REQ'(1) << owner_q : '0;
   always_comb begin
      state_d        = state_q;
      rr_d           = rr_q;
      owner_d        = owner_q;
      smp_d          = take ? smp_q + 1'b1 : smp_q;
      pls_d          = pulse ? pls_q + 1'b1 : pls_q;
      cyc_d          = cyc_q;
      ovf_d          = ovf_q | (pulse & dp_overflow);
      tmo            = 1'b0;
      dp_a_d         = take ? req_a[8*owner_q +: 8] : dp_a_q;
      dp_valid_in_d  = take;
      res_id_d       = res_id_q;
      res_g_d        = res_g_q;
      res_overflow_d = res_overflow_q;
      res_error_d    = res_error_q;
      case (state_q)
         IDLE: if (found) begin
            state_d = CLEAR;
            owner_d = pick;
            rr_d    = wrap(pick, 1);
         end
         CLEAR: begin
            state_d = STREAM;
            smp_d   = '0;
            pls_d   = '0;
            cyc_d   = '0;
            ovf_d   = 1'b0;
         end
         STREAM: state_d = !req[owner_q] ? ABORT : (take && smp_q == CW'(VEC_LEN - 1)) ? DRAIN : STREAM;
         ABORT: begin
            state_d     = RESULT;
            res_g_d     = '0;
            res_error_d = 1'b1;
         end
         DRAIN: begin
            cyc_d = cyc_q == TW'(TIMEOUT) ? cyc_q : cyc_q + 1'b1;
            if (pulse && pls_q == CW'(VEC_LEN - 1)) begin
               state_d     = RESULT;
               res_g_d     = dp_g;
               res_error_d = 1'b0;
            end else if (cyc_d == TW'(TIMEOUT)) begin
               state_d     = RESULT;
               tmo         = 1'b1;
               res_g_d     = '0;
               res_error_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      res_valid_d = state_d == RESULT;
      if (res_valid_d) begin
         res_id_d       = owner_q;
         res_overflow_d = ovf_d;
      end
      dp_reset_d = state_d == CLEAR || state_d == ABORT || tmo;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         rr_q           <= '0;
         owner_q        <= '0;
         smp_q          <= '0;
         pls_q          <= '0;
         cyc_q          <= '0;
         ovf_q          <= 1'b0;
         dp_reset_q     <= 1'b1;
         dp_a_q         <= '0;
         dp_valid_in_q  <= 1'b0;
         res_valid_q    <= 1'b0;
         res_id_q       <= '0;
         res_g_q        <= '0;
         res_overflow_q <= 1'b0;
         res_error_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         rr_q           <= rr_d;
         owner_q        <= owner_d;
         smp_q          <= smp_d;
         pls_q          <= pls_d;
         cyc_q          <= cyc_d;
         ovf_q          <= ovf_d;
         dp_reset_q     <= dp_reset_d;
         dp_a_q         <= dp_a_d;
         dp_valid_in_q  <= dp_valid_in_d;
         res_valid_q    <= res_valid_d;
         res_id_q       <= res_id_d;
         res_g_q        <= res_g_d;
         res_overflow_q <= res_overflow_d;
         res_error_q    <= res_error_d;
      end
   end
   assign dp_reset     = dp_reset_q;
   assign dp_a         = dp_a_q;
   assign dp_valid_in  = dp_valid_in_q;
   assign res_valid    = res_valid_q;
   assign res_id       = res_id_q;
   assign res_g        = res_g_q;
   assign res_overflow = res_overflow_q;
   assign res_error    = res_error_q;
endmodule

// File: tb/tb_l2_norm_arbiter.sv
// tb_l2_norm_arbiter: vector table plus reset/timeout sequences against a running-sum datapath model
module tb_l2_norm_arbiter;
   localparam int N = 4, L = 8, TMO = 64;
   logic clk = 1'b0, reset = 1'b1;
   logic [N-1:0] req = '0, req_valid = '0, gnt;
   logic [8*N-1:0] req_a = '0;
   logic dp_reset, dp_valid_in, dp_valid_out = 1'b0, dp_overflow = 1'b0;
   logic [7:0] dp_a;
   logic [9:0] dp_g = '0;
   logic res_valid, res_overflow, res_error;
   logic [1:0] res_id;
   logic [9:0] res_g;
   int vectors = 0, errors = 0;
   always #5 clk = ~clk;
   l2_norm_arbiter #(.NUM_REQ(N), .VEC_LEN(L), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_valid(req_valid), .gnt(gnt),
      .dp_reset(dp_reset), .dp_a(dp_a), .dp_valid_in(dp_valid_in), .dp_g(dp_g),
      .dp_valid_out(dp_valid_out), .dp_overflow(dp_overflow), .res_valid(res_valid),
      .res_id(res_id), .res_g(res_g), .res_overflow(res_overflow), .res_error(res_error)
   );
   logic [9:0] m_sum = '0, m_s1 = '0;
   logic m_v1 = 1'b0, m_sup = 1'b0, m_ovf = 1'b0;
   int m_cnt = 0;
   // datapath model: g is the running sum, valid_out two cycles after valid_in
   always @(posedge clk) begin
      if (dp_reset) begin
         m_sum <= '0; m_s1 <= '0; m_v1 <= 1'b0; m_cnt <= 0;
         dp_valid_out <= 1'b0; dp_overflow <= 1'b0; dp_g <= '0;
      end else begin
         m_v1 <= dp_valid_in;
         if (dp_valid_in) begin
            m_sum <= m_sum + 10'(dp_a);
            m_s1  <= m_sum + 10'(dp_a);
            m_cnt <= m_cnt + 1;
         end
         dp_valid_out <= m_v1 & ~m_sup;
         dp_overflow  <= m_v1 & m_ovf & (m_cnt == 4);
         if (m_v1) dp_g <= m_s1;
      end
   end
   typedef struct {
      logic [N-1:0] mask; int reps; logic [7:0] base, inc; int gap, drop; bit sup, ovf;
      int nres; logic [15:0] ids; logic [9:0] g; logic eovf, eerr; int erises;
   } vec_t;
   typedef struct { logic [1:0] id; logic [9:0] g; logic ovf, err; int cyc; } res_t;
   vec_t tbl[6];
   res_t got[$];
   int idx[N], want[N], gap[N], ph[N], drop_at[N];
   logic [7:0] base[N], inc[N];
   int cyc = 0, drain_cyc = -1, rises = 0;
   logic dpr_prev = 1'b0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req[i]           = want[i] > 0;
         req_valid[i]     = req[i] && ph[i] == 0 && idx[i] < L;
         req_a[8*i +: 8]  = base[i] + 8'(idx[i]) * inc[i];
      end
   endtask
   task automatic step();
      logic [N-1:0] tk, gp;
      logic [7:0] ta;
      tk = gnt & req_valid & {N{~reset}};
      gp = gnt;
      ta = '0;
      for (int i = 0; i < N; i++) if (tk[i]) ta = req_a[8*i +: 8];
      @(posedge clk);
      #1;
      cyc++;
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("dp_valid_in", 32'(dp_valid_in), 32'(|tk));
      if (|tk) check("dp_a", 32'(dp_a), 32'(ta));
      if (gp != '0 && gnt == '0) drain_cyc = cyc;
      if (dp_reset && !dpr_prev) rises++;
      dpr_prev = dp_reset;
      if (res_valid) got.push_back('{res_id, res_g, res_overflow, res_error, cyc});
      for (int i = 0; i < N; i++) begin
         if (tk[i]) idx[i]++;
         if (res_valid && int'(res_id) == i) begin
            idx[i] = 0;
            if (want[i] > 0) want[i]--;
         end
         if (idx[i] == drop_at[i]) want[i] = 0;
         ph[i] = ph[i] >= gap[i] ? 0 : ph[i] + 1;
      end
      drive();
   endtask
   task automatic start(input vec_t v);
      reset = 1'b1;
      for (int i = 0; i < N; i++) want[i] = 0;
      drive();
      repeat (2) step();
      reset = 1'b0;
      step();
      m_sup = v.sup; m_ovf = v.ovf;
      got.delete(); rises = 0; drain_cyc = -1;
      for (int i = 0; i < N; i++) begin
         want[i] = v.mask[i] ? v.reps : 0;
         idx[i] = 0; ph[i] = 0; gap[i] = v.gap; drop_at[i] = v.drop;
         base[i] = v.base; inc[i] = v.inc;
      end
      drive();
   endtask
   initial begin
      for (int i = 0; i < N; i++) begin
         idx[i] = 0; want[i] = 0; gap[i] = 0; ph[i] = 0; drop_at[i] = -1; base[i] = '0; inc[i] = '0;
      end
      tbl[0] = '{4'b0001, 1, 8'd1,  8'd1, 0, -1, 1'b0, 1'b0, 1, 16'h0000, 10'd36, 1'b0, 1'b0, 1};
      tbl[1] = '{4'b1111, 2, 8'd10, 8'd0, 0, -1, 1'b0, 1'b0, 8, 16'hE4E4, 10'd80, 1'b0, 1'b0, 8};
      tbl[2] = '{4'b0100, 1, 8'd5,  8'd0, 2, -1, 1'b0, 1'b0, 1, 16'h0002, 10'd40, 1'b0, 1'b0, 1};
      tbl[3] = '{4'b0010, 1, 8'd1,  8'd1, 0,  3, 1'b0, 1'b0, 1, 16'h0001, 10'd0,  1'b0, 1'b1, 2};
      tbl[4] = '{4'b1000, 1, 8'd3,  8'd0, 0, -1, 1'b1, 1'b0, 1, 16'h0003, 10'd0,  1'b0, 1'b1, 2};
      tbl[5] = '{4'b0001, 1, 8'd1,  8'd1, 0, -1, 1'b0, 1'b1, 1, 16'h0000, 10'd36, 1'b1, 1'b0, 1};
      drive();
      repeat (3) step();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_dp_reset", 32'(dp_reset), 32'd1);
      check("rst_dp_valid_in", 32'(dp_valid_in), 32'd0);
      check("rst_dp_a", 32'(dp_a), 32'd0);
      check("rst_res", 32'({res_valid, res_id, res_g, res_overflow, res_error}), 32'd0);
      for (int t = 0; t < 6; t++) begin
         start(tbl[t]);
         for (int c = 0; c < 600 && got.size() < tbl[t].nres; c++) step();
         repeat (12) step();
         check($sformatf("v%0d_count", t), 32'(got.size()), 32'(tbl[t].nres));
         for (int k = 0; k < got.size() && k < tbl[t].nres; k++) begin
            check($sformatf("v%0d_r%0d_id", t, k), 32'(got[k].id), 32'(tbl[t].ids[2*k +: 2]));
            check($sformatf("v%0d_r%0d_g", t, k), 32'(got[k].g), 32'(tbl[t].g));
            check($sformatf("v%0d_r%0d_ovf", t, k), 32'(got[k].ovf), 32'(tbl[t].eovf));
            check($sformatf("v%0d_r%0d_err", t, k), 32'(got[k].err), 32'(tbl[t].eerr));
         end
         check($sformatf("v%0d_dp_reset_pulses", t), 32'(rises), 32'(tbl[t].erises));
         if (tbl[t].sup && got.size() > 0)
            check("timeout_latency", 32'(got[0].cyc - drain_cyc), 32'(TMO));
      end
      // reset asserted in the middle of a stream must kill the vector silently
      start('{4'b1000, 1, 8'd1, 8'd1, 0, -1, 1'b0, 1'b0, 0, 16'h0, 10'd0, 1'b0, 1'b0, 0});
      for (int c = 0; c < 100 && idx[3] < 3; c++) step();
      check("midrst_streaming", 32'(idx[3] >= 3), 32'd1);
      reset = 1'b1;
      for (int i = 0; i < N; i++) want[i] = 0;
      drive();
      step();
      check("midrst_gnt", 32'(gnt), 32'd0);
      check("midrst_dp_reset", 32'(dp_reset), 32'd1);
      check("midrst_res_valid", 32'(res_valid), 32'd0);
      reset = 1'b0;
      repeat (30) step();
      check("midrst_no_result", 32'(got.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
